i2c_config_seq: RTL

Power-up register configuration sequencer that drives the write-request handshake of the I2C master controller. It steps through an external configuration table (codec/sensor init list), issuing one I2C register write per entry. It retries NACKed writes, inserts a programmable gap between transactions, and reports done or fail status to the system. It sits between the top-level reset/enable logic and the I2C master; a table ROM (sub-module) supplies entries.

---
 rtl/i2c_config_seq_pkg.sv | 31 +++
 rtl/i2c_config_lut.sv | 28 ++
 rtl/i2c_config_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/i2c_config_seq_pkg.sv
// Shared definitions for the I2C configuration sequencer: FSM states,
// table entry field layout and an entry-packing helper for table ROMs.
package i2c_config_seq_pkg;

    typedef enum logic [2:0] {
        S_INIT_WAIT = 3'd0,
        S_FETCH     = 3'd1,
        S_LATCH     = 3'd2,
        S_REQ       = 3'd3,
        S_NEXT      = 3'd4,
        S_GAP       = 3'd5,
        S_DONE      = 3'd6,
        S_FAIL      = 3'd7
    } state_t;

    localparam int unsigned DEV_LSB  = 24;
    localparam int unsigned REG_LSB  = 8;
    localparam int unsigned DATA_LSB = 0;

    // A delay of 0 behaves like 1: the wait state always lasts at least one cycle.
    function automatic logic delay_done(input logic [15:0] cnt, input logic [15:0] delay);
        return ({1'b0, cnt} + 17'd1) >= {1'b0, delay};
    endfunction

    function automatic logic [31:0] lut_entry(input logic [7:0] dev_a,
                                              input logic [15:0] reg_a,
                                              input logic [7:0] dat);
        return {dev_a, reg_a, dat};
    endfunction

endpackage

// File: rtl/i2c_config_lut.sv
// Codec power-up register table; registered output, one cycle after lut_index.
module i2c_config_lut
    import i2c_config_seq_pkg::*;
(
    input  logic        clk,
    input  logic [7:0]  lut_index,
    output logic [31:0] lut_data
);

    localparam logic [7:0] CODEC_DEV = 8'h34;

    always_ff @(posedge clk) begin
        case (lut_index)
            8'd0:    lut_data <= lut_entry(CODEC_DEV, 16'h000F, 8'h00);
            8'd1:    lut_data <= lut_entry(CODEC_DEV, 16'h0006, 8'h10);
            8'd2:    lut_data <= lut_entry(CODEC_DEV, 16'h0000, 8'h17);
            8'd3:    lut_data <= lut_entry(CODEC_DEV, 16'h0001, 8'h17);
            8'd4:    lut_data <= lut_entry(CODEC_DEV, 16'h0002, 8'h79);
            8'd5:    lut_data <= lut_entry(CODEC_DEV, 16'h0003, 8'h79);
            8'd6:    lut_data <= lut_entry(CODEC_DEV, 16'h0004, 8'h12);
            8'd7:    lut_data <= lut_entry(CODEC_DEV, 16'h0005, 8'h00);
            8'd8:    lut_data <= lut_entry(CODEC_DEV, 16'h0007, 8'h02);
            8'd9:    lut_data <= lut_entry(CODEC_DEV, 16'h0009, 8'h01);
            default: lut_data <= '0;
        endcase
    end

endmodule

// File: rtl/i2c_config_seq.sv
// Power-up configuration sequencer: walks the register table and issues one
// I2C write per entry, with NACK retries, inter-transaction gaps and status.
module i2c_config_seq
    import i2c_config_seq_pkg::*;
#(
    parameter int unsigned LUT_SIZE   = 10,
    parameter logic [15:0] INIT_DELAY = 16'd50000,
    parameter logic [15:0] GAP_CYCLES = 16'd1000,
    parameter int unsigned RETRY_MAX  = 3,
    parameter logic        ADDR_2BYTE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_start,
    output logic [7:0]  lut_index,
    input  logic [31:0] lut_data,
    output logic        i2c_addr_2byte,
    output logic        i2c_write_req,
    input  logic        i2c_write_req_ack,
    input  logic        i2c_error,
    output logic [7:0]  i2c_slave_dev_addr,
    output logic [15:0] i2c_slave_reg_addr,
    output logic [7:0]  i2c_write_data,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_fail,
    output logic [7:0]  fail_index
);

    localparam logic [7:0] LAST_IDX  = 8'(LUT_SIZE - 1);
    localparam logic [3:0] RETRY_LIM = 4'(RETRY_MAX);

    state_t      state, state_next;
    logic [15:0] cnt;
    logic [3:0]  retry_cnt;
    logic        retry_pend;
    logic        cnt_exp, is_last, can_retry;

    assign cnt_exp   = delay_done(cnt, (state == S_INIT_WAIT) ? INIT_DELAY : GAP_CYCLES);
    assign is_last   = (lut_index == LAST_IDX);
    assign can_retry = (retry_cnt < RETRY_LIM);

    assign i2c_addr_2byte = ADDR_2BYTE;
    assign i2c_write_req  = (state == S_REQ);
    assign cfg_busy       = !((state == S_DONE) || (state == S_FAIL));

    always_comb begin
        state_next = state;
        case (state)
            S_INIT_WAIT: if (cnt_exp) state_next = S_FETCH;
            S_FETCH:     state_next = S_LATCH;
            S_LATCH:     state_next = S_REQ;
            S_REQ: begin
                if (i2c_write_req_ack) begin
                    if (!i2c_error)     state_next = S_NEXT;
                    else if (can_retry) state_next = S_GAP;
                    else                state_next = S_FAIL;
                end
            end
            S_NEXT:      state_next = is_last ? S_DONE : S_GAP;
            // The gap serves both paths: a retry skips the table read.
            S_GAP:       if (cnt_exp) state_next = retry_pend ? S_REQ : S_FETCH;
            S_DONE,
            S_FAIL:      if (cfg_start) state_next = S_INIT_WAIT;
            default:     state_next = S_INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_INIT_WAIT;
            cnt                <= '0;
            retry_cnt          <= '0;
            retry_pend         <= 1'b0;
            lut_index          <= '0;
            i2c_slave_dev_addr <= '0;
            i2c_slave_reg_addr <= '0;
            i2c_write_data     <= '0;
            cfg_done           <= 1'b0;
            cfg_fail           <= 1'b0;
            fail_index         <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                cnt <= '0;
            else if ((state == S_INIT_WAIT) || (state == S_GAP))
                cnt <= cnt + 16'd1;

            case (state)
                S_LATCH: begin
                    i2c_slave_dev_addr <= lut_data[DEV_LSB +: 8];
                    i2c_slave_reg_addr <= lut_data[REG_LSB +: 16];
                    i2c_write_data     <= lut_data[DATA_LSB +: 8];
                    retry_cnt          <= '0;
                    retry_pend         <= 1'b0;
                end
                S_REQ: begin
                    if (i2c_write_req_ack && i2c_error) begin
                        if (can_retry) begin
                            retry_cnt  <= retry_cnt + 4'd1;
                            retry_pend <= 1'b1;
                        end else begin
                            cfg_fail   <= 1'b1;
                            fail_index <= lut_index;
                        end
                    end
                end
                S_NEXT: begin
                    if (is_last) begin
                        cfg_done <= 1'b1;
                    end else begin
                        lut_index  <= lut_index + 8'd1;
                        retry_pend <= 1'b0;
                    end
                end
                S_DONE,
                S_FAIL: begin
                    if (cfg_start) begin
                        lut_index <= '0;
                        cfg_done  <= 1'b0;
                        cfg_fail  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
